// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//
// Steps through a 512x8 microcode store and turns its contents into a stream
// of 6-bit control words. Each instruction costs one FETCH cycle (store read
// latency) and one EXEC cycle, plus HOLD cycles for EMIT (until the word is
// accepted) or WAIT cycles for WAIT (until the selected condition is true).
//
// Instruction encoding (uc_data_in):
//   00dddddd  EMIT d       present d on ctrl_data_out until accepted
//   01xxxxcc  WAIT cc      stall until cond_in[cc] is 1
//   10aaaaaa  JUMP a       continue at address {a,000}
//   11xxxxxx  HALT         pulse done_out and return to IDLE
//
// Ports:
//   clock_in        single clock, rising edge
//   reset_in        synchronous, active-high reset
//   start_in        run request, only honoured in IDLE
//   uc_addr_out     registered store address (the program counter)
//   uc_data_in      store read data, valid one cycle after the address changes
//   cond_in         wait conditions selected by WAIT
//   ctrl_data_out   emitted control word
//   ctrl_valid_out  ctrl_data_out holds an unaccepted word
//   ctrl_ready_in   consumer accepts the word
//   busy_out        high whenever the sequencer is not in IDLE
//   done_out        one-cycle pulse when a run ends
//   error_out       sticky WAIT timeout flag, cleared by the next start
//
// Optional feature: define MICROCODE_WAIT_TIMEOUT_EN to abort a WAIT whose
// condition stays false for 256 cycles (sets error_out, pulses done_out).
// Without it WAIT blocks indefinitely and error_out is tied low.

module microcode_sequencer (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       start_in,
    output logic [8:0] uc_addr_out,
    input  logic [7:0] uc_data_in,
    input  logic [3:0] cond_in,
    output logic [5:0] ctrl_data_out,
    output logic       ctrl_valid_out,
    input  logic       ctrl_ready_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       error_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HOLD,
        ST_WAIT
    } state_e;

    localparam logic [1:0] OP_EMIT = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b10;

    state_e     state_q, state_d;
    logic [8:0] pc_q, pc_d;
    logic [5:0] ctrl_data_q, ctrl_data_d;
    logic       ctrl_valid_q, ctrl_valid_d;
    logic       done_q, done_d;
    logic [1:0] cc_q, cc_d;
`ifdef MICROCODE_WAIT_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       error_q, error_d;
`endif

    // State register: reset wins over everything, including a pending start.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ctrl_data_q  <= '0;
            ctrl_valid_q <= 1'b0;
            done_q       <= 1'b0;
            cc_q         <= '0;
`ifdef MICROCODE_WAIT_TIMEOUT_EN
            wait_cnt_q   <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ctrl_data_q  <= ctrl_data_d;
            ctrl_valid_q <= ctrl_valid_d;
            done_q       <= done_d;
            cc_q         <= cc_d;
`ifdef MICROCODE_WAIT_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            error_q      <= error_d;
`endif
        end
    end

    // Next-state logic. Everything holds by default; done_d is a pulse and
    // therefore defaults low. The WAIT selector is captured in EXEC so the
    // wait does not depend on the store output staying stable.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ctrl_data_d  = ctrl_data_q;
        ctrl_valid_d = ctrl_valid_q;
        done_d       = 1'b0;
        cc_d         = cc_q;
`ifdef MICROCODE_WAIT_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        error_d      = error_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
`ifdef MICROCODE_WAIT_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end

            ST_FETCH: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                case (uc_data_in[7:6])
                    OP_EMIT: begin
                        ctrl_data_d  = uc_data_in[5:0];
                        ctrl_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                    end
                    OP_WAIT: begin
                        cc_d       = uc_data_in[1:0];
                        state_d    = ST_WAIT;
`ifdef MICROCODE_WAIT_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end
                    OP_JUMP: begin
                        pc_d    = {uc_data_in[5:0], 3'b000};
                        state_d = ST_FETCH;
                    end
                    default: begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end

            ST_HOLD: begin
                if (ctrl_valid_q && ctrl_ready_in) begin
                    ctrl_valid_d = 1'b0;
                    pc_d         = pc_q + 9'd1;
                    state_d      = ST_FETCH;
                end
            end

            ST_WAIT: begin
                // The condition is tested before the timeout so a condition
                // that comes true on the 256th cycle still resumes normally.
                if (cond_in[cc_q]) begin
                    pc_d    = pc_q + 9'd1;
                    state_d = ST_FETCH;
                end
`ifdef MICROCODE_WAIT_TIMEOUT_EN
                else if (wait_cnt_q == 8'hFF) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign uc_addr_out    = pc_q;
    assign ctrl_data_out  = ctrl_data_q;
    assign ctrl_valid_out = ctrl_valid_q;
    assign busy_out       = (state_q != ST_IDLE);
    assign done_out       = done_q;
`ifdef MICROCODE_WAIT_TIMEOUT_EN
    assign error_out      = error_q;
`else
    assign error_out      = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer.
// The expected per-cycle outputs of each run are produced by an
// instruction-level interpreter of the microcode program: it walks the
// program and lays down the cycles each instruction costs, given the
// pre-drawn ready/condition schedules. The DUT is then run against the same
// schedules and compared every cycle.

module tb_microcode_sequencer;

    localparam int CAP   = 700;
    localparam int MAXC  = CAP + 8;
    localparam int NEVER = 1000000;
`ifdef MICROCODE_WAIT_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       ready;
    logic [3:0] cond;
    logic [8:0] ucAddr;
    logic [7:0] ucData = 8'h00;
    logic [5:0] ctrlData;
    logic       ctrlValid;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clock = ~clock;

    microcode_sequencer dut (
        .clock_in       (clock),
        .reset_in       (reset),
        .start_in       (start),
        .uc_addr_out    (ucAddr),
        .uc_data_in     (ucData),
        .cond_in        (cond),
        .ctrl_data_out  (ctrlData),
        .ctrl_valid_out (ctrlValid),
        .ctrl_ready_in  (ready),
        .busy_out       (busy),
        .done_out       (done),
        .error_out      (err)
    );

    // Synchronous-read microcode store: data follows the address by one cycle.
    logic [7:0] store [512];
    always @(posedge clock) ucData <= store[ucAddr];

    // Per-cycle stimulus schedules and the store patch for the current run.
    logic       readyS [MAXC];
    logic [3:0] condS  [MAXC];
    logic       startS [MAXC];
    int         patchCycle;
    logic [8:0] patchAddr;
    logic [7:0] patchVal;
    int         resetAt;
    int         segLen;

    // Expected outputs per cycle.
    logic       expBusy  [MAXC];
    logic [8:0] expAddr  [MAXC];
    logic       expValid [MAXC];
    logic [5:0] expData  [MAXC];
    logic       expDone  [MAXC];
    logic       expErr   [MAXC];
    int         tExp;

    // Architectural state carried from one run to the next.
    logic [8:0] modelPc;
    logic [5:0] modelData;
    logic       modelErr;
    logic       modelHalted;

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic rdy, input logic [3:0] c);
        reset = rst;
        start = st;
        ready = rdy;
        cond  = c;
    endtask

    task automatic note(input logic b, input logic [8:0] a, input logic v,
                        input logic [5:0] d, input logic dn, input logic e);
        if (tExp < MAXC) begin
            expBusy[tExp]  = b;
            expAddr[tExp]  = a;
            expValid[tExp] = v;
            expData[tExp]  = d;
            expDone[tExp]  = dn;
            expErr[tExp]   = e;
        end
        tExp++;
    endtask

    // Interpret the program one instruction at a time, appending the cycles
    // each one occupies. Cycle 0 is the IDLE cycle in which start is raised.
    task automatic buildExpected();
        logic [8:0] pc;
        logic [5:0] data;
        logic       errFlag;
        logic [7:0] instr;
        int         waited;
        pc          = modelPc;
        data        = modelData;
        errFlag     = modelErr;
        modelHalted = 1'b0;
        tExp        = 0;
        note(1'b0, pc, 1'b0, data, 1'b0, errFlag);
        pc      = '0;
        errFlag = 1'b0;
        while (!modelHalted && tExp < CAP) begin
            instr = (tExp >= patchCycle && pc == patchAddr) ? patchVal : store[pc];
            note(1'b1, pc, 1'b0, data, 1'b0, errFlag);
            note(1'b1, pc, 1'b0, data, 1'b0, errFlag);
            case (instr[7:6])
                2'b00: begin
                    data = instr[5:0];
                    do begin
                        note(1'b1, pc, 1'b1, data, 1'b0, errFlag);
                    end while (!readyS[tExp-1] && tExp < CAP);
                    if (readyS[tExp-1]) pc = 9'((int'(pc) + 1) % 512);
                end
                2'b01: begin
                    waited = 0;
                    while (tExp < CAP) begin
                        note(1'b1, pc, 1'b0, data, 1'b0, errFlag);
                        waited++;
                        if (condS[tExp-1][instr[1:0]]) begin
                            pc = 9'((int'(pc) + 1) % 512);
                            break;
                        end
                        if (TIMEOUT_EN && waited == 256) begin
                            errFlag     = 1'b1;
                            modelHalted = 1'b1;
                            break;
                        end
                    end
                end
                2'b10: pc = 9'(int'(instr[5:0]) * 8);
                default: modelHalted = 1'b1;
            endcase
        end
        if (modelHalted) begin
            note(1'b0, pc, 1'b0, data, 1'b1, errFlag);
            note(1'b0, pc, 1'b0, data, 1'b0, errFlag);
            note(1'b0, pc, 1'b0, data, 1'b0, errFlag);
        end
        segLen    = (tExp < MAXC) ? tExp : MAXC;
        modelPc   = pc;
        modelData = data;
        modelErr  = errFlag;
    endtask

    task automatic clearSetup();
        for (int a = 0; a < 512; a++) store[a] = 8'hC0;
        for (int t = 0; t < MAXC; t++) begin
            readyS[t] = 1'b1;
            condS[t]  = 4'h0;
            startS[t] = 1'b0;
        end
        patchCycle = NEVER;
        patchAddr  = '0;
        patchVal   = 8'hC0;
        resetAt    = -1;
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " rst busy"},  busy,      0);
        checkOutput({name, " rst addr"},  ucAddr,    0);
        checkOutput({name, " rst valid"}, ctrlValid, 0);
        checkOutput({name, " rst data"},  ctrlData,  0);
        checkOutput({name, " rst done"},  done,      0);
        checkOutput({name, " rst err"},   err,       0);
    endtask

    task automatic runSegment(input string name);
        int last;
        buildExpected();
        startS[0] = 1'b1;
        for (int t = 1; t < segLen; t++)
            startS[t] = expBusy[t] && ($urandom_range(0, 9) == 0);
        if (resetAt >= segLen) resetAt = -1;
        if (!modelHalted && resetAt < 0) resetAt = segLen - 1;
        last = (resetAt >= 0) ? resetAt : segLen - 1;
        for (int t = 0; t <= last; t++) begin
            @(negedge clock);
            checkOutput($sformatf("%s busy@%0d", name, t),  busy,      expBusy[t]);
            checkOutput($sformatf("%s addr@%0d", name, t),  ucAddr,    expAddr[t]);
            checkOutput($sformatf("%s valid@%0d", name, t), ctrlValid, expValid[t]);
            checkOutput($sformatf("%s data@%0d", name, t),  ctrlData,  expData[t]);
            checkOutput($sformatf("%s done@%0d", name, t),  done,      expDone[t]);
            checkOutput($sformatf("%s err@%0d", name, t),   err,       expErr[t]);
            applyStimulus(t == resetAt, startS[t] || (t == resetAt), readyS[t], condS[t]);
            if (t == patchCycle) store[patchAddr] = patchVal;
        end
        if (resetAt >= 0) begin
            @(negedge clock);
            checkResetState(name);
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
            modelPc   = '0;
            modelData = '0;
            modelErr  = 1'b0;
        end
    endtask

    task automatic randomProgram();
        int addr;
        int n;
        int r;
        int blk;
        addr = 0;
        n    = $urandom_range(3, 14);
        for (int i = 0; i < n && addr < 511; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                store[addr] = {2'b00, 6'($urandom)};
                addr++;
            end else if (r < 85) begin
                store[addr] = {2'b01, 4'($urandom), 2'($urandom)};
                addr++;
            end else if ((addr / 8) < 63) begin
                blk         = $urandom_range(addr / 8 + 1, 63);
                store[addr] = {2'b10, 6'(blk)};
                addr        = blk * 8;
            end
        end
        store[addr] = 8'hC0;
        for (int t = 0; t < MAXC; t++) begin
            readyS[t] = ($urandom_range(0, 9) < 6);
            condS[t]  = 4'($urandom) & 4'($urandom);
        end
        if ($urandom_range(0, 4) == 0) resetAt = $urandom_range(1, 60);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearSetup();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
        repeat (2) @(negedge clock);
        checkResetState("init");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        modelPc   = '0;
        modelData = '0;
        modelErr  = 1'b0;

        // Two words then HALT, consumer always ready.
        clearSetup();
        store[0] = 8'h05; store[1] = 8'h3F; store[2] = 8'hC0;
        runSegment("emit3");

        // Consumer stalls for 10 HOLD cycles.
        clearSetup();
        store[0] = 8'h2A; store[1] = 8'hC0;
        for (int t = 0; t < 13; t++) readyS[t] = 1'b0;
        runSegment("hold");

        // WAIT on cond[2] raised after 7 WAIT cycles, other bits already high;
        // then a WAIT whose condition is already true at entry.
        clearSetup();
        store[0] = 8'h42; store[1] = 8'h07; store[2] = 8'h43; store[3] = 8'hC0;
        for (int t = 0; t < MAXC; t++) condS[t] = (t >= 10) ? 4'hF : 4'hB;
        runSegment("wait");

        // Condition never true: timeout with the option, stall without.
        clearSetup();
        store[0] = 8'h41;
        for (int t = 0; t < MAXC; t++) condS[t] = 4'hD;
        runSegment("timeout");

        // JUMP 0x85 lands on 0x028.
        clearSetup();
        store[0] = 8'h85; store[9'h028] = 8'h1C; store[9'h029] = 8'hC0;
        runSegment("jump");

        // Run up to address 511 and wrap onto a HALT patched in at address 0.
        clearSetup();
        store[0] = 8'hBF;
        for (int a = 504; a < 512; a++) store[a] = {2'b00, 6'($urandom)};
        patchCycle = 10; patchAddr = 9'd0; patchVal = 8'hC0;
        runSegment("wrap");

        // A JUMP to itself never terminates; reset ends it.
        clearSetup();
        store[0] = 8'h80;
        resetAt = 40;
        runSegment("selfjump");

        // Reset in HOLD and in WAIT (start is held high on the reset edge).
        clearSetup();
        store[0] = 8'h15;
        for (int t = 0; t < MAXC; t++) readyS[t] = 1'b0;
        resetAt = 6;
        runSegment("rsthold");

        clearSetup();
        store[0] = 8'h41;
        resetAt = 20;
        runSegment("rstwait");

        for (int s = 0; s < 30; s++) begin
            clearSetup();
            randomProgram();
            runSegment($sformatf("rand%0d", s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 The block SHALL have the port clock_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset_in, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port start_in, input, 1 bit: run request, sampled in IDLE only.
REQ-004 The block SHALL have the port uc_addr_out, output, 9 bits: registered microcode address to the 512x8 store.
REQ-005 The block SHALL have the port uc_data_in, input, 8 bits: store read data, valid one cycle after uc_addr_out changes.
REQ-006 The block SHALL have the port cond_in, input, 4 bits: wait conditions.
REQ-007 The block SHALL have the port ctrl_data_out, output, 6 bits: emitted control word.
REQ-008 The block SHALL have the port ctrl_valid_out, output, 1 bit: ctrl_data_out valid.
REQ-009 The block SHALL have the port ctrl_ready_in, input, 1 bit: consumer accepts the word.
REQ-010 The block SHALL have the port busy_out, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have the port done_out, output, 1 bit: one-cycle pulse on HALT.
REQ-012 The block SHALL have the port error_out, output, 1 bit: sticky timeout flag, cleared by start.

Function
REQ-013 Encoding SHALL be: 00dddddd = EMIT d; 01xxxxcc = WAIT on cond_in[cc]; 10aaaaaa = JUMP to {a,000}; 11xxxxxx = HALT.
REQ-014 States SHALL be IDLE, FETCH, EXEC, HOLD and WAIT; pc SHALL be a 9-bit register, and uc_addr_out SHALL equal pc.
REQ-015 IDLE with start_in=1 SHALL set pc=0, clear error_out and go to FETCH; start_in outside IDLE SHALL be ignored.
REQ-016 FETCH SHALL last exactly one cycle (store latency) and then go to EXEC.
REQ-017 EXEC EMIT SHALL register ctrl_data_out=d, set ctrl_valid_out=1 and go to HOLD.
REQ-018 In HOLD, when ctrl_valid_out and ctrl_ready_in are both 1, the block SHALL clear ctrl_valid_out, set pc=pc+1 and go to FETCH.
REQ-019 While ctrl_ready_in=0, ctrl_data_out SHALL be held stable.
REQ-020 EXEC WAIT SHALL go to WAIT; WAIT SHALL remain until cond_in[cc]=1, then set pc=pc+1 and go to FETCH.
REQ-021 A condition already true at entry SHALL still cost one WAIT cycle.
REQ-022 EXEC JUMP SHALL load pc={a,000} and go to FETCH; a JUMP to its own address is legal and loops forever.
REQ-023 EXEC HALT SHALL pulse done_out for exactly one cycle, go to IDLE and leave pc unchanged.
REQ-024 pc increment from 511 SHALL wrap to 0.
REQ-025 Minimum EMIT throughput SHALL be one word per 3 cycles (FETCH, EXEC, HOLD accepted).

Reset
REQ-026 When reset_in=1 on any edge, including mid-HOLD or mid-WAIT, the block SHALL go to IDLE with pc=0.
REQ-027 Reset SHALL clear ctrl_data_out, ctrl_valid_out, busy_out, done_out, error_out and the timeout counter; reset SHALL override start_in.

Configuration
REQ-028 The macro MICROCODE_WAIT_TIMEOUT_EN, when defined, SHALL add an 8-bit counter cleared on WAIT entry.
REQ-029 With MICROCODE_WAIT_TIMEOUT_EN, if the condition is still false after 256 WAIT cycles, the block SHALL set error_out, pulse done_out and go to IDLE.
REQ-030 Without MICROCODE_WAIT_TIMEOUT_EN, WAIT SHALL wait indefinitely, error_out SHALL be constant 0, and no counter SHALL exist.

Verification
REQ-031 Store 0x05,0x3F,0xC0 with ctrl_ready_in=1 and a start pulse -> ctrl words 0x05 then 0x3F, one per 3 cycles; done_out one cycle after HALT fetch; busy_out low afterwards.
REQ-032 EMIT 0x2A with ctrl_ready_in low for 10 cycles -> ctrl_valid_out and ctrl_data_out=0x2A stable for 10 cycles; pc advances only after acceptance.
REQ-033 WAIT 0x42 with cond_in[2] raised after 7 cycles -> remains in WAIT for 7 cycles and resumes at pc+1; with the macro and cond_in never raised -> error_out=1 and done_out pulse after 256 cycles.
REQ-034 JUMP 0x85 at addr 0 -> next fetch at addr 0x028; EMIT at addr 511 followed by HALT at addr 0 -> pc wraps to 0 and done_out pulses.
REQ-035 reset_in asserted in HOLD, and start_in asserted while busy -> IDLE with all outputs 0 after the reset edge; start while busy has no effect.
